// File: rtl/d_axi_bridge_pkg.sv
// Shared constants for the data/instruction AXI bridges and their arbiter:
// FSM state encodings, AXI burst/response codes and per-side IDs.
`timescale 1ns/1ps
package d_axi_bridge_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam logic [3:0] I_AXI_ID = 4'b0000;
  localparam logic [3:0] D_AXI_ID = 4'b0001;

  function automatic logic [2:0] axi_size(input logic [1:0] sz);
    return {1'b0, sz};
  endfunction

endpackage

// File: rtl/d_axi_bridge.sv
// Data-cache request port to a single-beat, single-outstanding AXI3 master.
// Define DBRIDGE_BUS_ERR_EN to add c_err, flagging non-OKAY rresp/bresp.
`timescale 1ns/1ps
module d_axi_bridge
  import d_axi_bridge_pkg::*;
#(
  parameter int         A_WIDTH = 32,
  parameter logic [3:0] AXI_ID  = D_AXI_ID
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH-1:0] c_a,
  input  logic [31:0]        c_din,
  output logic [31:0]        c_dout,
  input  logic               c_strobe,
  input  logic [3:0]         c_wen,
  input  logic [1:0]         c_size,
  input  logic               c_rw,
  output logic               c_ready,
  output logic [3:0]         arid,
  output logic [A_WIDTH-1:0] araddr,
  output logic [3:0]         arlen,
  output logic [2:0]         arsize,
  output logic [1:0]         arburst,
  output logic               arvalid,
  input  logic               arready,
  input  logic [3:0]         rid,
  input  logic [31:0]        rdata,
  input  logic [1:0]         rresp,
  input  logic               rlast,
  input  logic               rvalid,
  output logic               rready,
  output logic [3:0]         awid,
  output logic [A_WIDTH-1:0] awaddr,
  output logic [3:0]         awlen,
  output logic [2:0]         awsize,
  output logic [1:0]         awburst,
  output logic               awvalid,
  input  logic               awready,
  output logic [3:0]         wid,
  output logic [31:0]        wdata,
  output logic [3:0]         wstrb,
  output logic               wlast,
  output logic               wvalid,
  input  logic               wready,
  input  logic [3:0]         bid,
  input  logic [1:0]         bresp,
  input  logic               bvalid,
  output logic               bready
`ifdef DBRIDGE_BUS_ERR_EN
  ,
  output logic               c_err
`endif
);

  logic [2:0]         r_state;
  logic [A_WIDTH-1:0] r_addr;
  logic [31:0]        r_din;
  logic [3:0]         r_wen;
  logic [1:0]         r_size;
  logic [31:0]        r_dout;
  logic               r_aw_done;
  logic               r_w_done;
  logic               w_aw_fin;
  logic               w_w_fin;

  // Valids come from state/flags only, never from the ready inputs.
  assign arvalid = (r_state == S_RD_ADDR);
  assign rready  = (r_state == S_RD_DATA);
  assign awvalid = (r_state == S_WR_REQ) && !r_aw_done;
  assign wvalid  = (r_state == S_WR_REQ) && !r_w_done;
  assign bready  = (r_state == S_WR_RESP);
  assign c_ready = (r_state == S_DONE);
  assign c_dout  = r_dout;

  assign w_aw_fin = r_aw_done || (awvalid && awready);
  assign w_w_fin  = r_w_done || (wvalid && wready);

  assign arid    = AXI_ID;
  assign araddr  = r_addr;
  assign arlen   = 4'd0;
  assign arsize  = axi_size(r_size);
  assign arburst = BURST_INCR;
  assign awid    = AXI_ID;
  assign awaddr  = r_addr;
  assign awlen   = 4'd0;
  assign awsize  = axi_size(r_size);
  assign awburst = BURST_INCR;
  assign wid     = AXI_ID;
  assign wdata   = r_din;
  assign wstrb   = r_wen;
  assign wlast   = 1'b1;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_din     <= '0;
      r_wen     <= '0;
      r_size    <= '0;
      r_dout    <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (c_strobe) begin
            r_addr    <= c_a;
            r_din     <= c_din;
            r_wen     <= c_wen;
            r_size    <= c_size;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= c_rw ? S_WR_REQ : S_RD_ADDR;
          end
        end
        S_RD_ADDR: begin
          if (arready) r_state <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (rvalid) begin
            r_dout  <= rdata;
            r_state <= S_DONE;
          end
        end
        S_WR_REQ: begin
          // AW and W may complete in either order or together.
          r_aw_done <= w_aw_fin;
          r_w_done  <= w_w_fin;
          if (w_aw_fin && w_w_fin) r_state <= S_WR_RESP;
        end
        S_WR_RESP: begin
          if (bvalid) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DBRIDGE_BUS_ERR_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_err <= 1'b0;
    end else if (r_state == S_RD_DATA && rvalid) begin
      r_err <= (rresp != RESP_OKAY);
    end else if (r_state == S_WR_RESP && bvalid) begin
      r_err <= (bresp != RESP_OKAY);
    end
  end

  assign c_err = c_ready && r_err;

  logic w_unused;
  assign w_unused = ^{rid, rlast, bid};
`else
  logic w_unused;
  assign w_unused = ^{rid, rlast, bid, rresp, bresp};
`endif

endmodule
